// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared funct3 codes, FSM states and sub-word merge helper.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } state_t;

    function automatic logic [31:0] merge_word(
        input logic [31:0] word,
        input logic [31:0] data,
        input logic [2:0]  f3,
        input logic [1:0]  lo
    );
        logic [31:0] m;
        m = word;
        if (f3 == F3_B)
            m[{lo, 3'b000} +: 8] = data[7:0];
        else if (f3 == F3_H)
            m[{lo[1], 4'b0000} +: 16] = data[15:0];
        return m;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: picks the addressed lane of a memory word and sign/zero-extends it.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_rdata = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
                  (i_funct3 == F3_BU) ? {24'b0, w_byte} :
                  (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
                  (i_funct3 == F3_HU) ? {16'b0, w_half} :
                  (i_funct3 == F3_W)  ? i_word : '0;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I loads/stores onto a word memory; sub-word stores use a
// one-cycle read-modify-write that stalls the core.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        out_of_range,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [29:0] LIMIT = 30'(MEM_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [29:0] r_idx;
    logic [31:0] r_word;
    logic        w_idle;
    logic        w_half;
    logic        w_fault;
    logic        w_sw;
    logic        w_sub;
    logic [31:0] w_load;

    assign w_idle = (r_state == ST_IDLE);
    assign w_half = (funct3 == F3_H) || (funct3 == F3_HU);

    assign misaligned   = w_idle & req_valid &
                          ((w_half & addr[0]) | ((funct3 == F3_W) & (addr[1:0] != 2'b00)));
    assign out_of_range = w_idle & req_valid & (addr[31:2] >= LIMIT);
    assign w_fault      = misaligned | out_of_range;

    assign w_sw  = w_idle & req_valid & req_we & ~w_fault & (funct3 == F3_W);
    assign w_sub = w_idle & req_valid & req_we & ~w_fault & ((funct3 == F3_B) || (funct3 == F3_H));

    load_align u_align (
        .i_word   (mem_rd),
        .i_lo     (addr[1:0]),
        .i_funct3 (funct3),
        .o_rdata  (w_load)
    );

    assign rdata  = (w_idle & req_valid & ~req_we & ~w_fault) ? w_load : '0;
    assign stall  = w_sub;
    assign mem_a  = w_idle ? {2'b00, addr[31:2]} : {2'b00, r_idx};
    // A write held in WRITE is dropped if reset lands on that cycle.
    assign mem_we = ~reset & (w_sw | ~w_idle);
    assign mem_wd = w_idle ? wdata : r_word;

    always_comb begin
        w_next = ST_IDLE;
        if (w_sub)
            w_next = ST_WRITE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            if (w_sub) begin
                r_idx  <= addr[31:2];
                r_word <= merge_word(mem_rd, wdata, funct3, addr[1:0]);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test-plan cases plus random traffic checked every
// cycle against a transaction-level model of the unit and its memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int n_tests = 0;
    int n_fail  = 0;
    logic model_ready = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .stall        (stall),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .mem_a        (mem_a),
        .mem_we       (mem_we),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    assign mem_rd = (mem_a < 32'd1024) ? mem[mem_a[9:0]] : 32'h0;

    always @(posedge clk)
        if (mem_we && mem_a < 32'd1024)
            mem[mem_a[9:0]] <= mem_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks memory contents and a pending sub-word write.
    initial begin
        logic        m_pend;
        logic [31:0] m_idx, m_word, idx, cur, v, e_rd, e_a, e_wd;
        logic        e_mis, e_oor, e_st, e_we, fault;
        int sh;
        m_pend = 1'b0;
        m_idx  = '0;
        m_word = '0;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i]     = v;
            ref_mem[i] = v;
        end
        mem[0] = 32'h80FF_1234; ref_mem[0] = 32'h80FF_1234;
        mem[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;
        mem[2] = 32'h5566_7788; ref_mem[2] = 32'h5566_7788;
        mem[5] = 32'h0;         ref_mem[5] = 32'h0;
        model_ready = 1'b1;
        forever begin
            @(negedge clk);
            idx = addr >> 2;
            cur = (idx < 1024) ? ref_mem[idx[9:0]] : 32'h0;
            if (m_pend) begin
                e_rd = 0; e_st = 0; e_mis = 0; e_oor = 0;
                e_a = m_idx; e_wd = m_word; e_we = !reset;
            end else begin
                e_mis = req_valid && (((funct3 == 3'd1 || funct3 == 3'd5) && addr[0]) ||
                                      (funct3 == 3'd2 && addr[1:0] != 2'b00));
                e_oor = req_valid && (idx >= 1024);
                fault = e_mis || e_oor;
                e_a   = idx;
                e_rd  = 0;
                if (req_valid && !req_we && !fault) begin
                    sh = 8 * int'(addr[1:0]);
                    case (funct3)
                        3'd0: begin v = (cur >> sh) & 32'hFF; e_rd = (v >= 128) ? (v | 32'hFFFF_FF00) : v; end
                        3'd4: e_rd = (cur >> sh) & 32'hFF;
                        3'd1: begin v = (cur >> (addr[1] ? 16 : 0)) & 32'hFFFF; e_rd = (v >= 32768) ? (v | 32'hFFFF_0000) : v; end
                        3'd5: e_rd = (cur >> (addr[1] ? 16 : 0)) & 32'hFFFF;
                        3'd2: e_rd = cur;
                        default: e_rd = 0;
                    endcase
                end
                e_st = req_valid && req_we && !fault && (funct3 == 3'd0 || funct3 == 3'd1);
                e_we = !reset && req_valid && req_we && !fault && funct3 == 3'd2;
                e_wd = wdata;
            end
            chk("rdata", rdata, e_rd);
            chk("stall", {31'b0, stall}, {31'b0, e_st});
            chk("misaligned", {31'b0, misaligned}, {31'b0, e_mis});
            chk("out_of_range", {31'b0, out_of_range}, {31'b0, e_oor});
            chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
            chk("mem_a", mem_a, e_a);
            if (e_we)
                chk("mem_wd", mem_wd, e_wd);
            if (m_pend) begin
                if (!reset)
                    ref_mem[m_idx[9:0]] = m_word;
                m_pend = 1'b0;
            end else if (!reset) begin
                if (e_we) begin
                    ref_mem[idx[9:0]] = wdata;
                end else if (e_st) begin
                    m_pend = 1'b1;
                    m_idx  = idx;
                    if (funct3 == 3'd0) begin
                        sh = 8 * int'(addr[1:0]);
                        m_word = (cur & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
                    end else begin
                        sh = addr[1] ? 16 : 0;
                        m_word = (cur & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
                    end
                end
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        reset = r; req_valid = v; req_we = w; funct3 = f; addr = a; wdata = d;
        @(negedge clk);
    endtask

    initial begin
        int mism;
        wait (model_ready);
        step(1, 0, 0, 3'd0, 32'h0, 32'h0);
        step(1, 0, 0, 3'd0, 32'h0, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_mem_we", {31'b0, mem_we}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);

        step(0, 1, 0, 3'd0, 32'h3, 32'h0);
        chk("lb_sext", rdata, 32'hFFFF_FF80);
        step(0, 1, 0, 3'd4, 32'h3, 32'h0);
        chk("lbu_zext", rdata, 32'h0000_0080);
        chk("lbu_stall", {31'b0, stall}, 32'h0);

        step(0, 1, 1, 3'd0, 32'h6, 32'hAB);
        chk("sb_c1_stall", {31'b0, stall}, 32'h1);
        chk("sb_c1_we", {31'b0, mem_we}, 32'h0);
        step(0, 0, 0, 3'd0, 32'h0, 32'h0);
        chk("sb_c2_we", {31'b0, mem_we}, 32'h1);
        chk("sb_c2_a", mem_a, 32'h1);
        chk("sb_c2_wd", mem_wd, 32'h11AB_3344);
        step(0, 1, 0, 3'd2, 32'h4, 32'h0);
        chk("lw_after_sb", rdata, 32'h11AB_3344);

        step(0, 1, 1, 3'd1, 32'hA, 32'hBEEF);
        step(0, 0, 0, 3'd0, 32'h0, 32'h0);
        step(0, 1, 0, 3'd2, 32'h8, 32'h0);
        chk("lw_after_sh", rdata, 32'hBEEF_7788);
        step(0, 1, 1, 3'd1, 32'h9, 32'h1234);
        chk("sh_misaligned", {31'b0, misaligned}, 32'h1);
        chk("sh_mis_we", {31'b0, mem_we}, 32'h0);
        step(0, 1, 0, 3'd2, 32'h8, 32'h0);
        chk("word2_kept", rdata, 32'hBEEF_7788);

        step(0, 1, 0, 3'd2, 32'h1000, 32'h0);
        chk("lw_oor", {31'b0, out_of_range}, 32'h1);
        chk("lw_oor_rdata", rdata, 32'h0);
        step(0, 1, 1, 3'd2, 32'h1000, 32'hDEAD_BEEF);
        chk("sw_oor_we", {31'b0, mem_we}, 32'h0);

        step(0, 1, 1, 3'd0, 32'h14, 32'h77);
        step(1, 0, 0, 3'd0, 32'h0, 32'h0);
        chk("reset_write_we", {31'b0, mem_we}, 32'h0);
        step(0, 1, 0, 3'd2, 32'h14, 32'h0);
        chk("word5_unchanged", rdata, 32'h0);
        chk("post_reset_stall", {31'b0, stall}, 32'h0);

        step(0, 1, 1, 3'd0, 32'h14, 32'h11);
        step(0, 0, 0, 3'd0, 32'h0, 32'h0);
        step(0, 1, 1, 3'd0, 32'h15, 32'h22);
        step(0, 0, 0, 3'd0, 32'h0, 32'h0);
        step(0, 1, 0, 3'd2, 32'h14, 32'h0);
        chk("sb_b2b", rdata, 32'h0000_2211);
        chk("sb_b2b_mem", mem[5], 32'h0000_2211);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = ($urandom % 16 == 0) ? ($urandom | 32'h0000_1000) : $urandom_range(0, 255);
            step(($urandom % 50) == 0, ($urandom % 5) != 0, $urandom % 2, 3'($urandom % 8),
                 a, $urandom);
        end
        step(0, 0, 0, 3'd0, 32'h0, 32'h0);
        step(0, 0, 0, 3'd0, 32'h0, 32'h0);
        mism = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_mem[i])
                mism++;
        chk("final_mem_mismatches", 32'(mism), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
